layer_arb2: RTL

Two-requester arbiter and sequencer for one shared fully-connected layer engine (an M-output, N-input, T-bit layer with valid/ready streaming ports). It grants the engine to one requester for a whole transaction: N input words in, then M output words back to the same requester. It sits between two upstream vector producers and a single layer instance, so two streams can share one set of weight/bias ROMs and one MAC datapath.

---
 rtl/layer_arb2.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/layer_arb2.sv
// layer_arb2: two-requester arbiter/sequencer for one shared layer engine.
// Ports: clk, reset (sync, active-low); per requester X in {0,1}:
//   sX_valid/sX_ready/sX_data (input words), mX_valid/mX_ready/mX_data
//   (results); engine side eng_s_valid/eng_s_ready/eng_data_in,
//   eng_m_valid/eng_m_ready/eng_data_out; status grant, busy.
// Option: LAYER_ARB_FIXED_PRI_EN gives requester 0 fixed tie priority.
module layer_arb2 #(
  parameter int M = 5,
  parameter int N = 2,
  parameter int T = 9
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         s0_valid,
  output logic         s0_ready,
  input  logic [T-1:0] s0_data,
  output logic         m0_valid,
  input  logic         m0_ready,
  output logic [T-1:0] m0_data,
  input  logic         s1_valid,
  output logic         s1_ready,
  input  logic [T-1:0] s1_data,
  output logic         m1_valid,
  input  logic         m1_ready,
  output logic [T-1:0] m1_data,
  output logic         eng_s_valid,
  input  logic         eng_s_ready,
  output logic [T-1:0] eng_data_in,
  input  logic         eng_m_valid,
  output logic         eng_m_ready,
  input  logic [T-1:0] eng_data_out,
  output logic         grant,
  output logic         busy
);

  localparam int IW = $clog2(N + 1);
  localparam int OW = $clog2(M + 1);

  typedef enum logic [1:0] {
    IDLE,
    FEED,
    DRAIN
  } state_t;

  state_t        r_state;
  state_t        w_next;
  logic          r_grant;
  logic [IW-1:0] r_in_cnt;
  logic [OW-1:0] r_out_cnt;
  logic          w_win;
  logic          w_req;
  logic          w_sg_valid;
  logic          w_mg_ready;
  logic          w_in_hs;
  logic          w_out_hs;
  logic          w_in_last;
  logic          w_out_last;

  assign w_req      = s0_valid | s1_valid;
  assign w_sg_valid = r_grant ? s1_valid : s0_valid;
  assign w_mg_ready = r_grant ? m1_ready : m0_ready;
  assign w_in_hs    = (r_state == FEED) && w_sg_valid && eng_s_ready;
  assign w_out_hs   = (r_state == DRAIN) && eng_m_valid && w_mg_ready;
  assign w_in_last  = w_in_hs && (r_in_cnt == IW'(N - 1));
  assign w_out_last = w_out_hs && (r_out_cnt == OW'(M - 1));

`ifdef LAYER_ARB_FIXED_PRI_EN
  // Requester 0 wins whenever it asks.
  assign w_win = ~s0_valid;
`else
  logic r_rr_ptr;

  // Tie goes to rr_ptr; otherwise the lone requester wins.
  assign w_win = (s0_valid && s1_valid) ? r_rr_ptr : s1_valid;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_rr_ptr <= 1'b0;
    end else if (w_out_last) begin
      r_rr_ptr <= ~r_grant;
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:    if (w_req)      w_next = FEED;
      FEED:    if (w_in_last)  w_next = DRAIN;
      DRAIN:   if (w_out_last) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_grant   <= 1'b0;
      r_in_cnt  <= '0;
      r_out_cnt <= '0;
    end else begin
      if (r_state == IDLE && w_req) begin
        r_grant  <= w_win;
        r_in_cnt <= '0;
      end
      if (w_in_hs) begin
        r_in_cnt <= r_in_cnt + IW'(1);
      end
      if (w_in_last) begin
        r_out_cnt <= '0;
      end
      if (w_out_hs) begin
        r_out_cnt <= r_out_cnt + OW'(1);
      end
    end
  end

  always_comb begin
    s0_ready    = 1'b0;
    s1_ready    = 1'b0;
    m0_valid    = 1'b0;
    m1_valid    = 1'b0;
    m0_data     = '0;
    m1_data     = '0;
    eng_s_valid = 1'b0;
    eng_data_in = '0;
    eng_m_ready = 1'b0;
    unique case (r_state)
      FEED: begin
        eng_s_valid = w_sg_valid;
        eng_data_in = r_grant ? s1_data : s0_data;
        s0_ready    = ~r_grant & eng_s_ready;
        s1_ready    = r_grant & eng_s_ready;
      end
      DRAIN: begin
        m0_valid    = ~r_grant & eng_m_valid;
        m1_valid    = r_grant & eng_m_valid;
        m0_data     = r_grant ? '0 : eng_data_out;
        m1_data     = r_grant ? eng_data_out : '0;
        eng_m_ready = w_mg_ready;
      end
      default: ;
    endcase
  end

  assign grant = r_grant;
  assign busy  = (r_state != IDLE);

endmodule
